// File: rtl/noc_input_req_ctrl_pkg.sv
// Shared definitions for the input-port requester: port count, FSM states and
// the layout of a buffered flit entry.
package noc_input_req_ctrl_pkg;

  // Highest output-port index; masks are PORT+1 bits wide.
  localparam int PORT  = 4;
  localparam int NPORT = PORT + 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_REQ   = 2'd2
  } state_e;

  // Flit entry layout, MSB first: {multi, dst[NPORT-1:0], data[data_w-1:0]}.
  function automatic int ent_w(input int data_w);
    return data_w + NPORT + 1;
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Small synchronous FIFO with wrapping pointers and an occupancy counter.
module noc_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic                    do_push, do_pop;

  // A push while full is dropped even if a pop happens the same cycle.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_input_req_ctrl.sv
// Input-port requester: buffers flits, raises unicast/multicast requests toward
// each destination output arbiter, fires granted outputs and retires the head
// once every destination in its mask has been served.
module noc_input_req_ctrl
  import noc_input_req_ctrl_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int AGE_W  = 8
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [NPORT-1:0]  in_dst,
  input  logic              in_multi,
  output logic [NPORT-1:0]  u_req,
  output logic [NPORT-1:0]  m_req,
  input  logic [NPORT-1:0]  grt,
  output logic [DATA_W-1:0] out_data,
  output logic [NPORT-1:0]  out_fire,
  output logic [AGE_W-1:0]  head_age,
  output logic              err_grant
);
  localparam int EW = ent_w(DATA_W);
  localparam int CW = $clog2(DEPTH) + 1;

  state_e             state, state_nxt;
  logic [NPORT-1:0]   pending;
  logic [EW-1:0]      fifo_wdata, fifo_rdata;
  logic               fifo_full, fifo_empty;
  logic [CW-1:0]      fifo_count;

  logic               accept, push, drop, retire, stray, in_req;
  logic               head_multi;
  logic [NPORT-1:0]   head_dst, served, remain;
  logic [DATA_W-1:0]  head_data;

  assign in_ready   = !fifo_full;
  assign accept     = in_valid && in_ready;
  // An empty destination mask can never be served, so it is never buffered.
  assign push       = accept && (in_dst != '0);
  assign drop       = accept && (in_dst == '0);
  assign fifo_wdata = {in_multi, in_dst, in_data};

  assign head_multi = fifo_rdata[EW-1];
  assign head_dst   = fifo_rdata[EW-2 -: NPORT];
  assign head_data  = fifo_rdata[DATA_W-1:0];

  // The arbiter is combinational, so grants are consumed in the cycle they arrive.
  assign in_req = (state == ST_REQ);
  assign served = in_req ? (grt & pending) : '0;
  assign remain = pending & ~served;
  assign retire = in_req && (remain == '0);
  assign stray  = in_req && ((grt & ~pending) != '0);

  noc_sync_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk   (clk),
    .rst_  (rst_),
    .push  (push),
    .pop   (retire),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= ST_EMPTY;
    else       state <= state_nxt;
  end

  // Next-state: a fresh head always passes through LOAD, giving one bubble.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_EMPTY: if (push || !fifo_empty) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_REQ;
      ST_REQ:   if (retire)
                  state_nxt = ((fifo_count > CW'(1)) || push) ? ST_LOAD : ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  // Request/fire outputs come from registered state only; grt only gates fire.
  always_comb begin
    u_req    = '0;
    m_req    = '0;
    out_data = '0;
    out_fire = served;
    if (in_req) begin
      out_data = head_data;
      if (head_multi) m_req = pending;
      else            u_req = pending;
    end
  end

  // Remaining-destination mask: loaded from the head, shrinks as outputs are served.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)                  pending <= '0;
    else if (state == ST_LOAD)  pending <= head_dst;
    else if (in_req)            pending <= remain;
  end

  // Head wait counter: counts unserved REQ cycles, saturating, held on partial service.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)
      head_age <= '0;
    else if (state == ST_LOAD)
      head_age <= '0;
    else if (in_req && (served == '0) && (head_age != '1))
      head_age <= head_age + AGE_W'(1);
  end

  // Sticky error: stray grant bit or a dropped empty-mask flit.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)              err_grant <= 1'b0;
    else if (stray || drop) err_grant <= 1'b1;
  end

endmodule

// File: tb/tb_noc_input_req_ctrl.sv
// Bench for noc_input_req_ctrl: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_noc_input_req_ctrl;
  logic        clk;
  logic        rst_;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_dst;
  logic        in_multi;
  logic [4:0]  u_req;
  logic [4:0]  m_req;
  logic [4:0]  grt;
  logic [31:0] out_data;
  logic [4:0]  out_fire;
  logic [7:0]  head_age;
  logic        err_grant;

  int errors = 0;
  int checks = 0;

  noc_input_req_ctrl #(.DEPTH(4), .DATA_W(32), .AGE_W(8)) dut (
    .clk(clk), .rst_(rst_), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dst(in_dst), .in_multi(in_multi),
    .u_req(u_req), .m_req(m_req), .grt(grt), .out_data(out_data),
    .out_fire(out_fire), .head_age(head_age), .err_grant(err_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ = 1'b0; in_valid = 0; in_data = '0; in_dst = '0; in_multi = 0; grt = '0;
    repeat (2) @(posedge clk);
    #1 rst_ = 1'b1;
  endtask

  task automatic push1(input logic [4:0] d, input logic m, input logic [31:0] p);
    in_valid = 1; in_dst = d; in_multi = m; in_data = p;
    tick();
    in_valid = 0; in_dst = '0; in_multi = 0; in_data = '0;
  endtask

  task automatic test_reset();
    do_reset();
    push1(5'b00001, 0, 32'h11);
    tick();
    rst_ = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b exp 1", in_ready); end
    checks++; if (u_req !== 5'b0) begin errors++; $display("FAIL rst_u_req: got %b exp 0", u_req); end
    checks++; if (m_req !== 5'b0) begin errors++; $display("FAIL rst_m_req: got %b exp 0", m_req); end
    checks++; if (out_fire !== 5'b0) begin errors++; $display("FAIL rst_out_fire: got %b exp 0", out_fire); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data: got %h exp 0", out_data); end
    checks++; if (head_age !== 8'h0) begin errors++; $display("FAIL rst_head_age: got %0d exp 0", head_age); end
    checks++; if (err_grant !== 1'b0) begin errors++; $display("FAIL rst_err_grant: got %b exp 0", err_grant); end
  endtask

  task automatic test_unicast();
    do_reset();
    push1(5'b00100, 0, 32'hA5);              // t0 -> now t1
    tick();                                   // t2
    grt = 5'b00100; #1;
    checks++; if (u_req !== 5'b00100) begin errors++; $display("FAIL uni_u_req: got %b exp 00100", u_req); end
    checks++; if (m_req !== 5'b0) begin errors++; $display("FAIL uni_m_req: got %b exp 0", m_req); end
    checks++; if (out_fire !== 5'b00100) begin errors++; $display("FAIL uni_fire: got %b exp 00100", out_fire); end
    checks++; if (out_data !== 32'hA5) begin errors++; $display("FAIL uni_data: got %h exp a5", out_data); end
    tick(); grt = '0; #1;                     // t3
    checks++; if (u_req !== 5'b0) begin errors++; $display("FAIL uni_retire: got %b exp 0", u_req); end
    checks++; if (head_age !== 8'h0) begin errors++; $display("FAIL uni_age: got %0d exp 0", head_age); end
  endtask

  task automatic test_multicast_split();
    do_reset();
    push1(5'b10011, 1, 32'hC0DE);
    tick();                                   // t2
    grt = 5'b00001; #1;
    checks++; if (m_req !== 5'b10011) begin errors++; $display("FAIL mc_req_t2: got %b exp 10011", m_req); end
    checks++; if (u_req !== 5'b0) begin errors++; $display("FAIL mc_ureq: got %b exp 0", u_req); end
    checks++; if (out_fire !== 5'b00001) begin errors++; $display("FAIL mc_fire_t2: got %b exp 00001", out_fire); end
    tick(); grt = '0; #1;                     // t3
    checks++; if (m_req !== 5'b10010) begin errors++; $display("FAIL mc_req_t3: got %b exp 10010", m_req); end
    checks++; if (out_fire !== 5'b0) begin errors++; $display("FAIL mc_fire_t3: got %b exp 0", out_fire); end
    tick(); grt = 5'b10010; #1;               // t4
    checks++; if (out_fire !== 5'b10010) begin errors++; $display("FAIL mc_fire_t4: got %b exp 10010", out_fire); end
    checks++; if (out_data !== 32'hC0DE) begin errors++; $display("FAIL mc_data: got %h exp c0de", out_data); end
    checks++; if (head_age !== 8'd1) begin errors++; $display("FAIL mc_age: got %0d exp 1", head_age); end
    tick(); grt = '0; #1;                     // t5
    checks++; if (m_req !== 5'b0) begin errors++; $display("FAIL mc_pop: got %b exp 0", m_req); end
  endtask

  task automatic test_backpressure();
    logic [31:0] pay [4];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pay[i] = 32'hB000_0000 + 32'(i);
      push1(5'b00001, 0, pay[i]);
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got %b exp 0", in_ready); end
    push1(5'b00001, 0, 32'hDEAD);             // ignored: FIFO full
    for (int k = 0; k < 4; k++) begin
      int n;
      n = 0;
      while (u_req === 5'b0 && n < 4) begin tick(); n++; end
      checks++; if (u_req !== 5'b00001) begin errors++; $display("FAIL bp_req%0d: got %b exp 00001", k, u_req); end
      grt = 5'b00001; #1;
      checks++; if (out_data !== pay[k]) begin errors++; $display("FAIL bp_data%0d: got %h exp %h", k, out_data, pay[k]); end
      tick(); grt = '0; #1;
      checks++; if (u_req !== 5'b0) begin errors++; $display("FAIL bp_bubble%0d: got %b exp 0", k, u_req); end
    end
    repeat (3) tick();
    checks++; if (u_req !== 5'b0) begin errors++; $display("FAIL bp_fifth: got %b exp 0", u_req); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready: got %b exp 1", in_ready); end
  endtask

  task automatic test_stray();
    do_reset();
    push1(5'b00010, 0, 32'h77);
    tick();
    grt = 5'b01000; #1;
    checks++; if (out_fire !== 5'b0) begin errors++; $display("FAIL stray_fire: got %b exp 0", out_fire); end
    tick(); grt = '0; #1;
    checks++; if (err_grant !== 1'b1) begin errors++; $display("FAIL stray_err: got %b exp 1", err_grant); end
    checks++; if (u_req !== 5'b00010) begin errors++; $display("FAIL stray_req: got %b exp 00010", u_req); end
    grt = 5'b00010; tick(); grt = '0; tick();
    checks++; if (err_grant !== 1'b1) begin errors++; $display("FAIL stray_sticky: got %b exp 1", err_grant); end
  endtask

  task automatic test_age_sat();
    do_reset();
    push1(5'b00001, 0, 32'h5);
    tick();
    repeat (300) tick();
    checks++; if (head_age !== 8'd255) begin errors++; $display("FAIL age_sat: got %0d exp 255", head_age); end
    repeat (3) tick();
    checks++; if (head_age !== 8'd255) begin errors++; $display("FAIL age_hold: got %0d exp 255", head_age); end
    grt = 5'b00001; #1;
    checks++; if (out_fire !== 5'b00001) begin errors++; $display("FAIL age_fire: got %b exp 00001", out_fire); end
    tick(); grt = '0; #1;
    checks++; if (u_req !== 5'b0) begin errors++; $display("FAIL age_pop: got %b exp 0", u_req); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push1(5'b11000, 1, 32'h99);
    tick();
    grt = 5'b01000; tick(); grt = '0; #1;
    checks++; if (m_req !== 5'b10000) begin errors++; $display("FAIL rm_partial: got %b exp 10000", m_req); end
    grt = 5'b10000;
    rst_ = 1'b0; #1;
    checks++; if (m_req !== 5'b0) begin errors++; $display("FAIL rm_mreq: got %b exp 0", m_req); end
    checks++; if (out_fire !== 5'b0) begin errors++; $display("FAIL rm_fire: got %b exp 0", out_fire); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_ready: got %b exp 1", in_ready); end
    grt = '0;
    tick(); tick();
    rst_ = 1'b1;
    push1(5'b00010, 0, 32'h5A);
    tick();
    grt = 5'b00010; #1;
    checks++; if (out_fire !== 5'b00010) begin errors++; $display("FAIL rm_next_fire: got %b exp 00010", out_fire); end
    checks++; if (out_data !== 32'h5A) begin errors++; $display("FAIL rm_next_data: got %h exp 5a", out_data); end
    tick(); grt = '0;
  endtask

  typedef struct {
    logic [31:0] data;
    logic [4:0]  dst;
    logic        multi;
  } flit_t;

  // Reference model: queue of buffered flits; the head becomes requestable two
  // cycles after it becomes the head (arrival into an empty queue or pop of the
  // previous head), and retires when its remaining mask empties.
  task automatic test_random();
    flit_t       q[$];
    flit_t       f;
    bit          act, err_m, rdy;
    logic [4:0]  pend, served, eu, em, ef;
    logic [31:0] ed;
    int          wcnt, age, r;
    do_reset();
    act = 0; err_m = 0; pend = '0; wcnt = 0; age = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = $urandom;
      in_multi = 1'($urandom_range(0, 1));
      in_dst   = ($urandom_range(0, 15) == 0) ? 5'b0 : 5'($urandom_range(1, 31));
      r = $urandom_range(0, 19);
      if (r < 8)       grt = '0;
      else if (r < 19) grt = pend & 5'($urandom);
      else             grt = 5'($urandom);
      #2;
      rdy = (q.size() < 4);
      eu = (act && !q[0].multi) ? pend : 5'b0;
      em = (act &&  q[0].multi) ? pend : 5'b0;
      ef = act ? (grt & pend) : 5'b0;
      ed = act ? q[0].data : 32'h0;
      checks++; if (in_ready !== rdy) begin errors++; $display("FAIL rnd_ready c%0d: got %b exp %b", cyc, in_ready, rdy); end
      checks++; if (u_req !== eu) begin errors++; $display("FAIL rnd_u_req c%0d: got %b exp %b", cyc, u_req, eu); end
      checks++; if (m_req !== em) begin errors++; $display("FAIL rnd_m_req c%0d: got %b exp %b", cyc, m_req, em); end
      checks++; if (out_fire !== ef) begin errors++; $display("FAIL rnd_fire c%0d: got %b exp %b", cyc, out_fire, ef); end
      checks++; if (out_data !== ed) begin errors++; $display("FAIL rnd_data c%0d: got %h exp %h", cyc, out_data, ed); end
      checks++; if (err_grant !== err_m) begin errors++; $display("FAIL rnd_err c%0d: got %b exp %b", cyc, err_grant, err_m); end
      if (act) begin
        checks++; if (head_age !== 8'(age)) begin errors++; $display("FAIL rnd_age c%0d: got %0d exp %0d", cyc, head_age, age); end
      end
      // advance model to the next cycle
      served = act ? (grt & pend) : 5'b0;
      if (act && ((grt & ~pend) != 5'b0)) err_m = 1;
      if (act) begin
        if (served == 5'b0 && age < 255) age++;
        pend = pend & ~served;
        if (pend == 5'b0) begin
          void'(q.pop_front());
          act = 0;
        end
      end else if (wcnt > 0) begin
        wcnt--;
        if (wcnt == 0) begin
          act = 1; pend = q[0].dst; age = 0;
        end
      end
      if (in_valid && rdy) begin
        if (in_dst == 5'b0) err_m = 1;
        else begin
          f.data = in_data; f.dst = in_dst; f.multi = in_multi;
          q.push_back(f);
        end
      end
      if (!act && wcnt == 0 && q.size() > 0) wcnt = 1;
      if (!act) pend = '0;
      @(posedge clk); #1;
    end
    in_valid = 0; grt = '0;
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_multicast_split();
    test_backpressure();
    test_stray();
    test_age_sat();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/noc_input_req_ctrl.md
Name: noc_input_req_ctrl

Overview:
- Per-input-port requester that sits on the far side of the output-port fixed-priority arbiters.
- Buffers incoming flits in a small FIFO and drives unicast or multicast requests toward the arbiters of every destination output port.
- Consumes the per-output grant bits and fires the head flit into the crossbar for each granted output.
- Retires the head flit only after every destination in its mask has been served, so a multicast flit may be delivered across several cycles.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2).
- DATA_W, 32, flit payload width.
- AGE_W, 8, width of the saturating head-wait counter.

Ports:
- clk  in  1  clock.
- rst_  in  1  reset. Asynchronous, active-low.
- in_valid  in  1  upstream flit present.
- in_ready  out  1  FIFO can accept; equals !full.
- in_data  in  DATA_W  flit payload.
- in_dst  in  `PORT+1  destination output-port mask, bit i = output i.
- in_multi  in  1  flit is multicast.
- u_req  out  `PORT+1  unicast request; bit i goes to output i's arbiter.
- m_req  out  `PORT+1  multicast request; bit i goes to output i's arbiter.
- grt  in  `PORT+1  grant returned from output i's arbiter for this input.
- out_data  out  DATA_W  head payload to the crossbar.
- out_fire  out  `PORT+1  crossbar enable for output i this cycle.
- head_age  out  AGE_W  cycles the current head has waited.
- err_grant  out  1  sticky flag: a grant arrived on an unrequested bit.

Behaviour:
- Reset (async, rst_=0): FIFO empty, state EMPTY, pending=0.
  - All outputs 0 except in_ready=1.
  - Reset mid-multicast discards the flit and its partial progress.
- Push: when in_valid && in_ready, store {in_data, in_dst, in_multi}.
  - A flit with in_dst==0 is dropped: it is not stored and sets err_grant.
- States:
  - EMPTY: FIFO empty; nothing requested.
  - LOAD: the head entry is copied into the pending register, then the block goes to REQ. A flit pushed into an empty FIFO at cycle t is in LOAD at t+1 and issues its first request at t+2.
  - REQ: pending != 0.
    - Unicast head: u_req = pending, m_req = 0.
    - Multicast head: m_req = pending, u_req = 0.
    - Requests are registered-state driven, with no combinational path from grt.
- Grant handling in REQ:
  - served = grt & pending; out_fire = served in the same cycle (the arbiter is combinational); out_data = head payload.
  - Next cycle, pending <= pending & ~served.
  - If grt & ~pending != 0, set err_grant. Stray grant bits never fire.
- Retire: when pending & ~served == 0, pop the head.
  - If the FIFO is still non-empty, go to LOAD, else EMPTY. This gives one bubble cycle between consecutive heads.
- Requests are never withdrawn before they are granted. A partially served multicast keeps requesting only its remaining bits.
- head_age:
  - Cleared on LOAD.
  - Increments each REQ cycle in which served==0, saturating at all-ones.
  - Holds its value on partial service.
- FIFO: read and write pointers are log2(DEPTH) bits wide and wrap; count is log2(DEPTH)+1 bits.
  - A push and pop in the same cycle is legal when not full.
  - When full, in_ready=0 and pushes are ignored even if a pop occurs that cycle.
- err_grant clears only on reset.

Decomposition:
- Shared package/`define.h` holds:
  - `PORT and the port index defines.
  - State encodings ST_EMPTY=2'd0, ST_LOAD=2'd1, ST_REQ=2'd2.
  - A flit-entry field layout {multi, dst, data}.
- One natural sub-module: noc_sync_fifo, a DEPTH x (DATA_W+`PORT+2) synchronous FIFO with full/empty flags and async active-low reset.

Test Plan:
- Unicast basic: push dst=5'b00100, multi=0, data=0xA5 at t0; grt=5'b00100 at t2 -> u_req=00100 at t2, out_fire=00100 and out_data=0xA5 at t2, FIFO empty and u_req=0 at t3.
- Multicast split: push dst=5'b10011, multi=1; grant 00001 at t2, 10010 at t4 -> m_req goes 10011 -> 10010; out_fire=00001 then 10010; pop after t4; head_age=1 at t4.
- Backpressure: push 4 flits with grt=0 -> in_ready=0 after the 4th; a 5th push is ignored; grant each head in turn -> the 4 payloads emerge in order with one bubble between heads.
- Stray grant: head unicast dst=00010, drive grt=01000 -> out_fire=0, err_grant=1 sticky, request still 00010.
- Age saturation: hold grt=0 for 300 cycles with AGE_W=8 -> head_age=255 and stays 255; grant -> pop.
- Reset mid-multicast: after a partial grant on dst 11000, assert rst_ asynchronously -> all requests and out_fire drop immediately, in_ready=1, the next pushed flit is served normally.
